// File: rtl/axi_read_outstanding_limiter_if.sv
// ----------------------------------------------------------------------------
// axi_read_outstanding_limiter_if
//
// Purpose : AXI4 read-address (AR) and read-data (R) channel bundle used on
//           both sides of axi_read_outstanding_limiter. Write channels are not
//           part of this bundle because they bypass the limiter.
//
// Parameters:
//   C_ID_WIDTH    AR/R ID width
//   C_ADDR_WIDTH  AR address width
//   C_DATA_WIDTH  R data width
//
// Modports:
//   master : drives AR payload/arvalid and rready; receives arready and R.
//   slave  : receives AR payload/arvalid and rready; drives arready and R.
// ----------------------------------------------------------------------------
interface axi_read_outstanding_limiter_if #(
    parameter int C_ID_WIDTH   = 16,
    parameter int C_ADDR_WIDTH = 40,
    parameter int C_DATA_WIDTH = 128
);

    // AR channel
    logic [C_ID_WIDTH-1:0]   arid;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    // R channel
    logic [C_ID_WIDTH-1:0]   rid;
    logic [C_DATA_WIDTH-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_read_outstanding_limiter.sv
// ----------------------------------------------------------------------------
// axi_read_outstanding_limiter
//
// Purpose : Read-path stage placed directly after the bank-colouring address
//           translator. It caps the number of read bursts in flight toward the
//           memory controller so that per-core interference stays bounded for
//           MemorEDF scheduling. Accepted ARs increment a counter, completed
//           bursts (R beats carrying RLAST) decrement it, and AR acceptance is
//           stalled while the counter sits at MAX_OUTSTANDING.
//
// Build option:
//   ARSLICE_EN  defined   -> single-entry registered AR slice (1-cycle AR
//                            latency, 1 AR/cycle throughput).
//               undefined -> combinational AR path (0 latency).
//
// Parameters:
//   C_ID_WIDTH       AR/R ID width
//   C_ADDR_WIDTH     AR address width
//   C_DATA_WIDTH     R data width
//   MAX_OUTSTANDING  maximum read bursts in flight (1..255)
//   CNT_WIDTH        width of outstanding_count; must hold MAX_OUTSTANDING
//
// Ports:
//   s00_axi_aclk       in   single clock
//   s00_axi_aresetn    in   asynchronous active-low reset
//   s00_axi            slave modport  : AR in from translator, R back to it
//   m00_axi            master modport : AR out to memory, R in from memory
//   outstanding_count  out  bursts accepted and not yet completed
//   ar_stall           out  AR pending at s00 while the cap is reached
//   stall_cycles       out  saturating count of cycles with ar_stall high
//   err_underflow      out  sticky: RLAST completed while the count was 0
// ----------------------------------------------------------------------------
module axi_read_outstanding_limiter #(
    parameter int C_ID_WIDTH      = 16,
    parameter int C_ADDR_WIDTH    = 40,
    parameter int C_DATA_WIDTH    = 128,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    axi_read_outstanding_limiter_if.slave  s00_axi,
    axi_read_outstanding_limiter_if.master m00_axi,
    output logic [CNT_WIDTH-1:0]          outstanding_count,
    output logic                          ar_stall,
    output logic [31:0]                   stall_cycles,
    output logic                          err_underflow
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    // AR payload flattened: id, addr, len(8), size(3), burst(2), lock(1),
    // cache(4), prot(3), qos(4).
    localparam int AR_PL_W = C_ID_WIDTH + C_ADDR_WIDTH + 25;
    // R payload flattened: id, data, resp(2), last(1).
    localparam int R_PL_W  = C_ID_WIDTH + C_DATA_WIDTH + 3;

    logic [AR_PL_W-1:0]   s_ar_pl;
    logic [AR_PL_W-1:0]   m_ar_pl;
    logic [R_PL_W-1:0]    r_pl;

    logic                 room;
    logic                 ar_acc;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 underflow_set;

    // ------------------------------------------------------------------
    // Common terms. room looks only at the registered count, so a burst
    // completing in the cap cycle frees a slot one cycle later.
    // ------------------------------------------------------------------
    assign room   = (outstanding_count < MAX_CNT);
    assign ar_acc = s00_axi.arvalid & s00_axi.arready;
    assign r_done = m00_axi.rvalid & m00_axi.rready & m00_axi.rlast;

    assign ar_stall = s00_axi.arvalid & (outstanding_count == MAX_CNT);

    assign s_ar_pl = {s00_axi.arid,    s00_axi.araddr, s00_axi.arlen,
                      s00_axi.arsize,  s00_axi.arburst, s00_axi.arlock,
                      s00_axi.arcache, s00_axi.arprot,  s00_axi.arqos};

    assign {m00_axi.arid,    m00_axi.araddr, m00_axi.arlen,
            m00_axi.arsize,  m00_axi.arburst, m00_axi.arlock,
            m00_axi.arcache, m00_axi.arprot,  m00_axi.arqos} = m_ar_pl;

    // ------------------------------------------------------------------
    // R channel: zero-latency pass-through in both directions.
    // ------------------------------------------------------------------
    assign r_pl = {m00_axi.rid, m00_axi.rdata, m00_axi.rresp, m00_axi.rlast};
    assign {s00_axi.rid, s00_axi.rdata, s00_axi.rresp, s00_axi.rlast} = r_pl;
    assign s00_axi.rvalid = m00_axi.rvalid;
    assign m00_axi.rready = s00_axi.rready;

    // ------------------------------------------------------------------
    // AR path
    // ------------------------------------------------------------------
`ifdef ARSLICE_EN
    typedef enum logic {
        SLICE_EMPTY,
        SLICE_FULL
    } slice_state_t;

    slice_state_t       slice_state;
    slice_state_t       slice_state_next;
    logic [AR_PL_W-1:0] ar_pl_q;
    logic               held;

    assign held = (slice_state == SLICE_FULL);

    // A held AR leaving this cycle makes space, so a new one can be taken
    // in the same cycle; arready does not look at arvalid.
    assign s00_axi.arready = room & (~held | m00_axi.arready);
    assign m00_axi.arvalid = held;
    assign m_ar_pl         = ar_pl_q;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        slice_state_next = slice_state;
        unique case (slice_state)
            SLICE_EMPTY: begin
                if (ar_acc) slice_state_next = SLICE_FULL;
            end
            SLICE_FULL: begin
                // A refill in the drain cycle keeps the slice full.
                if (!ar_acc && m00_axi.arready) slice_state_next = SLICE_EMPTY;
            end
            default: slice_state_next = SLICE_EMPTY;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            slice_state <= SLICE_EMPTY;
            // NOTE: this is a single pipeline register, not a memory array,
            // and downstream observers expect a defined all-zero payload out
            // of reset, so it shares the async reset.
            ar_pl_q     <= '0;
        end else begin
            slice_state <= slice_state_next;
            if (ar_acc) ar_pl_q <= s_ar_pl;
        end
    end
`else
    // Combinational path: the limiter only gates the handshake. Neither
    // side's ready is derived from its own valid.
    assign m00_axi.arvalid = s00_axi.arvalid & room;
    assign s00_axi.arready = m00_axi.arready & room;
    assign m_ar_pl         = s_ar_pl;
`endif

    // ------------------------------------------------------------------
    // Outstanding-burst counter. The count moves on the s00-side
    // acceptance in both AR modes, so a slice-held AR already counts.
    // ar_acc cannot occur at the cap (room gates arready), so +1 never
    // overflows; a completion at zero is reported instead of wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        count_next    = outstanding_count;
        underflow_set = 1'b0;
        unique case ({ar_acc, r_done})
            2'b10: count_next = outstanding_count + 1'b1;
            2'b01: begin
                if (outstanding_count == '0) underflow_set = 1'b1;
                else                         count_next    = outstanding_count - 1'b1;
            end
            default: count_next = outstanding_count;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            outstanding_count <= '0;
            stall_cycles      <= '0;
            err_underflow     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            outstanding_count <= count_next;
            if (underflow_set) err_underflow <= 1'b1;
            if (ar_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_outstanding_limiter.sv
// ----------------------------------------------------------------------------
// tb_axi_read_outstanding_limiter
//
// Directed bench for axi_read_outstanding_limiter (MAX_OUTSTANDING = 4).
// Stimulus pushes expected AR/R transactions into queues; a monitor pops and
// compares whenever a handshake is visible on the DUT outputs. Status outputs
// are checked inline against hand-computed values. Works with and without
// ARSLICE_EN.
// ----------------------------------------------------------------------------
module tb_axi_read_outstanding_limiter;

    localparam int IDW  = 16;
    localparam int AW   = 40;
    localparam int DW   = 128;
    localparam int MAXO = 4;
    localparam int CW   = 8;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        logic           lock;
        logic [3:0]     cache;
        logic [2:0]     prot;
        logic [3:0]     qos;
    } ar_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } r_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] outstanding_count;
    logic          ar_stall;
    logic [31:0]   stall_cycles;
    logic          err_underflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    ar_t ar_q[$];
    r_t  r_q[$];

    always #5 clk = ~clk;

    axi_read_outstanding_limiter_if #(.C_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) s_if ();
    axi_read_outstanding_limiter_if #(.C_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) m_if ();

    axi_read_outstanding_limiter #(
        .C_ID_WIDTH      (IDW),
        .C_ADDR_WIDTH    (AW),
        .C_DATA_WIDTH    (DW),
        .MAX_OUTSTANDING (MAXO),
        .CNT_WIDTH       (CW)
    ) dut (
        .s00_axi_aclk      (clk),
        .s00_axi_aresetn   (rst_n),
        .s00_axi           (s_if),
        .m00_axi           (m_if),
        .outstanding_count (outstanding_count),
        .ar_stall          (ar_stall),
        .stall_cycles      (stall_cycles),
        .err_underflow     (err_underflow)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic ar_t mk_ar(input int i);
        ar_t a;
        a.id    = 16'h0100 + 16'(i);
        a.addr  = 40'h00_8000_0000 + 40'(i) * 40'h1040;
        a.len   = 8'(i + 3);
        a.size  = 3'd4;
        a.burst = 2'b01;
        a.lock  = 1'(i);
        a.cache = 4'(i + 2);
        a.prot  = 3'(i);
        a.qos   = 4'(15 - i);
        return a;
    endfunction

    function automatic r_t mk_r(input int i, input bit last);
        r_t b;
        b.id   = 16'hA000 + 16'(i);
        b.data = {32'(i) * 32'h0101_0101, 32'hDEAD_BEEF ^ 32'(i),
                  32'h1234_5678 + 32'(i), ~32'(i)};
        b.resp = 2'(i);
        b.last = last;
        return b;
    endfunction

    task automatic set_ar(input ar_t a, input logic v);
        s_if.arid    = a.id;
        s_if.araddr  = a.addr;
        s_if.arlen   = a.len;
        s_if.arsize  = a.size;
        s_if.arburst = a.burst;
        s_if.arlock  = a.lock;
        s_if.arcache = a.cache;
        s_if.arprot  = a.prot;
        s_if.arqos   = a.qos;
        s_if.arvalid = v;
    endtask

    task automatic set_r(input r_t b, input logic v);
        m_if.rid    = b.id;
        m_if.rdata  = b.data;
        m_if.rresp  = b.resp;
        m_if.rlast  = b.last;
        m_if.rvalid = v;
    endtask

    // Single-cycle completion beat; the caller deasserts rvalid afterwards.
    task automatic rlast_beat(input int i);
        r_t b;
        next_cycle();
        b = mk_r(i, 1'b1);
        set_r(b, 1'b1);
        r_q.push_back(b);
        settle();
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every handshake seen on m00 AR and s00 R.
    // ------------------------------------------------------------------
    ar_t got_ar;
    ar_t exp_ar;
    r_t  got_r;
    r_t  exp_r;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.arvalid && m_if.arready) begin
                got_ar = '{m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst,
                           m_if.arlock, m_if.arcache, m_if.arprot, m_if.arqos};
                if (ar_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL ar_unexpected: got AR %0h, expected none (t=%0t)", got_ar, $time);
                end else begin
                    exp_ar = ar_q.pop_front();
                    check("m00_ar_payload", 256'(got_ar), 256'(exp_ar));
                end
            end
            if (s_if.rvalid && s_if.rready) begin
                got_r = '{s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast};
                if (r_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL r_unexpected: got R %0h, expected none (t=%0t)", got_r, $time);
                end else begin
                    exp_r = r_q.pop_front();
                    check("s00_r_beat", 256'(got_r), 256'(exp_r));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        ar_t             a;
        r_t              b;
        int              beat;
        int              pushed;
        int              cyc;
        logic [15:0]     rdy_pat;

        rst_n = 1'b0;
        set_ar(mk_ar(0), 1'b0);
        set_r(mk_r(0, 1'b0), 1'b0);
        m_if.arready = 1'b1;
        s_if.rready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        settle();
        check("rst_count",     outstanding_count, 0);
        check("rst_stall_cyc", stall_cycles,      0);
        check("rst_err",       err_underflow,     0);
        check("rst_m_arvalid", m_if.arvalid,      0);
        check("rst_ar_stall",  ar_stall,          0);
        check("rst_s_arready", s_if.arready,      1);

        // Four back-to-back ARs fill the cap
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            a = mk_ar(i);
            set_ar(a, 1'b1);
            ar_q.push_back(a);
            settle();
            check("fill_count",   outstanding_count, i);
            check("fill_arready", s_if.arready,      1);
        end

        // Fifth AR is held at the cap
        next_cycle();
        a = mk_ar(4);
        set_ar(a, 1'b1);
        ar_q.push_back(a);
        settle();
        check("cap_count",    outstanding_count, 4);
        check("cap_arready",  s_if.arready,      0);
        check("cap_ar_stall", ar_stall,          1);
        check("cap_stall_0",  stall_cycles,      0);
        for (int j = 1; j <= 3; j++) begin
            next_cycle();
            settle();
            check("cap_stall_inc", stall_cycles, j);
            check("cap_arready",   s_if.arready, 0);
        end

        // One completion at the cap: arready stays low this cycle, rises next
        next_cycle();
        b = mk_r(0, 1'b1);
        set_r(b, 1'b1);
        r_q.push_back(b);
        settle();
        check("rdone_cap_count",   outstanding_count, 4);
        check("rdone_cap_arready", s_if.arready,      0);
        check("rdone_cap_stall",   stall_cycles,      4);
        next_cycle();
        m_if.rvalid = 1'b0;
        settle();
        check("after_rdone_count",   outstanding_count, 3);
        check("after_rdone_arready", s_if.arready,      1);
        check("after_rdone_stall",   ar_stall,          0);
        next_cycle();
        s_if.arvalid = 1'b0;
        settle();
        check("refill_count", outstanding_count, 4);
        check("refill_stall", stall_cycles,      5);

        // Drain to 2
        rlast_beat(1);
        rlast_beat(2);
        next_cycle();
        m_if.rvalid = 1'b0;
        settle();
        check("drain2_count", outstanding_count, 2);

        // Simultaneous acceptance and completion at count 2
        next_cycle();
        a = mk_ar(6);
        set_ar(a, 1'b1);
        ar_q.push_back(a);
        b = mk_r(3, 1'b1);
        set_r(b, 1'b1);
        r_q.push_back(b);
        settle();
        check("both_arready", s_if.arready, 1);
        next_cycle();
        s_if.arvalid = 1'b0;
        m_if.rvalid  = 1'b0;
        settle();
        check("both_count", outstanding_count, 2);

        // Drain to 0, then an extra completion underflows
        rlast_beat(4);
        rlast_beat(5);
        next_cycle();
        m_if.rvalid = 1'b0;
        settle();
        check("drain0_count", outstanding_count, 0);
        check("drain0_err",   err_underflow,     0);
        rlast_beat(6);
        check("uflow_err_pre", err_underflow, 0);
        next_cycle();
        m_if.rvalid = 1'b0;
        settle();
        check("uflow_count", outstanding_count, 0);
        check("uflow_err",   err_underflow,     1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            check("uflow_err_sticky", err_underflow, 1);
        end

        // 8-beat burst with toggling rready: zero-latency bit-exact pass-through
        rdy_pat = 16'b1011_0110_1011_0101;
        beat    = 0;
        pushed  = -1;
        cyc     = 0;
        while (beat < 8 && cyc < 16) begin
            next_cycle();
            b = mk_r(beat, beat == 7);
            set_r(b, 1'b1);
            s_if.rready = rdy_pat[cyc];
            if (pushed != beat) begin
                r_q.push_back(b);
                pushed = beat;
            end
            settle();
            check("burst_rdata",  s_if.rdata,   b.data);
            check("burst_rid",    s_if.rid,     b.id);
            check("burst_rresp",  s_if.rresp,   b.resp);
            check("burst_rlast",  s_if.rlast,   b.last);
            check("burst_rvalid", s_if.rvalid,  1);
            check("burst_rready", m_if.rready,  s_if.rready);
            if (s_if.rready) beat++;
            cyc++;
        end
        check("burst_complete", beat, 8);
        next_cycle();
        m_if.rvalid = 1'b0;
        s_if.rready = 1'b1;

        // m00 backpressure for 5 cycles: AR held stable at m00
        m_if.arready = 1'b0;
        a = mk_ar(5);
        a.addr = 40'h00_1234_5000;
        set_ar(a, 1'b1);
        ar_q.push_back(a);
`ifdef ARSLICE_EN
        settle();
        check("bp_slice_accept", s_if.arready, 1);
        next_cycle();
        s_if.arvalid = 1'b0;
        s_if.araddr  = '1;
`endif
        for (int k = 0; k < 5; k++) begin
            settle();
            check("bp_m_arvalid", m_if.arvalid, 1);
            check("bp_m_araddr",  m_if.araddr,  40'h00_1234_5000);
            check("bp_s_arready", s_if.arready, 0);
            next_cycle();
        end
        m_if.arready = 1'b1;
        next_cycle();
        s_if.arvalid = 1'b0;
        settle();
        check("bp_done_arvalid", m_if.arvalid,      0);
        check("bp_done_count",   outstanding_count, 1);

        // Build count 3 with an AR held, then reset mid-operation
        next_cycle();
        a = mk_ar(7);
        set_ar(a, 1'b1);
        ar_q.push_back(a);
        next_cycle();
        a = mk_ar(8);
        set_ar(a, 1'b1);
`ifdef ARSLICE_EN
        next_cycle();
        m_if.arready = 1'b0;
        s_if.arvalid = 1'b0;
`else
        ar_q.push_back(a);
        next_cycle();
        m_if.arready = 1'b0;
        set_ar(mk_ar(9), 1'b1);
`endif
        settle();
        check("pre_rst_count",   outstanding_count, 3);
        check("pre_rst_arvalid", m_if.arvalid,      1);
        #1;
        rst_n        = 1'b0;
        s_if.arvalid = 1'b0;
        m_if.rvalid  = 1'b0;
        #1;
        check("midrst_count",   outstanding_count, 0);
        check("midrst_stall",   stall_cycles,      0);
        check("midrst_err",     err_underflow,     0);
        check("midrst_arvalid", m_if.arvalid,      0);
        check("midrst_ar_stall", ar_stall,         0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        m_if.arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("post_rst_arvalid", m_if.arvalid,      0);
            check("post_rst_count",   outstanding_count, 0);
            next_cycle();
        end

        // Late completion after reset passes through and flags underflow
        b = mk_r(9, 1'b1);
        set_r(b, 1'b1);
        r_q.push_back(b);
        settle();
        check("late_rlast", s_if.rlast,    1);
        check("late_err_0", err_underflow, 0);
        next_cycle();
        m_if.rvalid = 1'b0;
        settle();
        check("late_err_1", err_underflow,     1);
        check("late_count", outstanding_count, 0);

        repeat (3) next_cycle();
        check("ar_queue_drained", ar_q.size(), 0);
        check("r_queue_drained",  r_q.size(),  0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
